// File: rtl/inst_pkg.sv
// Shared constants for the command-to-instruction expander: opcodes,
// instruction-word bit positions, the idle word and the FSM encoding.
package inst_pkg;

    localparam int LEN_NIJ = 36;
    localparam int KSIZE   = 3;
    localparam int IN_W    = 6;
    localparam int AW      = 11;
    localparam int INST_W  = 34;

    localparam logic [2:0] OP_NOP         = 3'd0;
    localparam logic [2:0] OP_XMEM_WR     = 3'd1;
    localparam logic [2:0] OP_IFIFO_FILL  = 3'd2;
    localparam logic [2:0] OP_LOAD        = 3'd3;
    localparam logic [2:0] OP_L0_FILL     = 3'd4;
    localparam logic [2:0] OP_EXEC        = 3'd5;
    localparam logic [2:0] OP_OFIFO_DRAIN = 3'd6;
    localparam logic [2:0] OP_ACC         = 3'd7;

    localparam int ACC_BIT      = 33;
    localparam int CEN_P_BIT    = 32;
    localparam int WEN_P_BIT    = 31;
    localparam int A_P_LSB      = 20;
    localparam int CEN_X_BIT    = 19;
    localparam int WEN_X_BIT    = 18;
    localparam int A_X_LSB      = 7;
    localparam int OFIFO_RD_BIT = 6;
    localparam int IFIFO_WR_BIT = 5;
    localparam int IFIFO_RD_BIT = 4;
    localparam int L0_RD_BIT    = 3;
    localparam int L0_WR_BIT    = 2;
    localparam int EXEC_BIT     = 1;
    localparam int LOAD_BIT     = 0;

    // Both SRAMs disabled and write-inhibited; every strobe low.
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP
    } state_t;

endpackage

// File: rtl/acc_addr_gen.sv
// Walks the ksize x ksize psum read pattern for the ACC op using only an
// adder and a column counter; o_addr is the address of the next beat.
module acc_addr_gen #(
    parameter int AW      = 11,
    parameter int LEN_NIJ = 36,
    parameter int KSIZE   = 3,
    parameter int IN_W    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic          i_step,
    output logic [AW-1:0] o_addr
);

    localparam int KCW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    // Next kij moves one pmem slice forward; a column wrap also moves one
    // input row down and back ksize-1 columns.
    localparam logic [AW-1:0] STEP_COL = AW'(LEN_NIJ + 1);
    localparam logic [AW-1:0] STEP_ROW = AW'(LEN_NIJ + IN_W - KSIZE + 1);
    localparam logic [KCW-1:0] KC_LAST = KCW'(KSIZE - 1);

    logic [AW-1:0]  r_addr;
    logic [KCW-1:0] r_kc;

    logic [AW-1:0]  w_src_addr;
    logic [KCW-1:0] w_src_kc;
    logic           w_wrap;
    logic [AW-1:0]  w_next_addr;
    logic [KCW-1:0] w_next_kc;

    // Start computes beat 1 from the base directly, since beat 0 is the base.
    always_comb begin
        w_src_addr  = i_start ? i_base : r_addr;
        w_src_kc    = i_start ? '0 : r_kc;
        w_wrap      = (w_src_kc == KC_LAST);
        w_next_addr = w_src_addr + (w_wrap ? STEP_ROW : STEP_COL);
        w_next_kc   = w_wrap ? '0 : w_src_kc + KCW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_kc   <= '0;
        end else if (i_start || i_step) begin
            r_addr <= w_next_addr;
            r_kc   <= w_next_kc;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/inst_gen.sv
// Expands one host command per handshake into a cycle-by-cycle 34-bit core
// instruction stream, followed by a one-cycle idle gap carrying done.
module inst_gen
    import inst_pkg::*;
#(
    parameter int len_nij = LEN_NIJ,
    parameter int ksize   = KSIZE,
    parameter int in_w    = IN_W,
    parameter int aw      = AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [aw-1:0]     cmd_addr,
    input  logic [aw-1:0]     cmd_len,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int CW = aw + 1;
    localparam int KK = ksize * ksize;
    localparam logic [CW-1:0] ACC_BEATS = CW'(KK + 1);
    localparam logic [CW-1:0] ACC_LAST  = CW'(KK);
    localparam logic [CW-1:0] ACC_STOP  = CW'(KK - 1);

    state_t            r_state;
    logic [2:0]        r_op;
    logic [aw-1:0]     r_base;
    logic [CW-1:0]     r_k;
    logic [CW-1:0]     r_n;
    logic [INST_W-1:0] r_inst;
    logic              r_done;

    logic              w_in_idle;
    logic              w_accept;
    logic              w_cmd_empty;
    logic [CW-1:0]     w_cmd_n;
    logic [2:0]        w_b_op;
    logic [aw-1:0]     w_b_lin;
    logic [aw-1:0]     w_b_acc_addr;
    logic              w_b_acc;
    logic              w_b_acc_last;
    logic [INST_W-1:0] w_beat;
    logic [aw-1:0]     w_acc_addr;
    logic              w_acc_start;
    logic              w_acc_step;

    assign w_in_idle = (r_state == ST_IDLE);
    assign cmd_ready = w_in_idle && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_cmd_n = '0;
        case (cmd_op)
            OP_XMEM_WR, OP_LOAD, OP_EXEC, OP_OFIFO_DRAIN: w_cmd_n = {1'b0, cmd_len};
            OP_IFIFO_FILL, OP_L0_FILL:                    w_cmd_n = {1'b0, cmd_len} + CW'(1);
            OP_ACC:                                       w_cmd_n = ACC_BEATS;
            default:                                      w_cmd_n = '0;
        endcase
        w_cmd_empty = (cmd_op == OP_NOP) || ((cmd_op != OP_ACC) && (cmd_len == '0));
    end

    // Beat 0 is built straight from the command inputs on the accept edge;
    // later beats come from the latched command and the beat counter.
    always_comb begin
        w_b_op       = w_in_idle ? cmd_op : r_op;
        w_b_lin      = w_in_idle ? cmd_addr : r_base + r_k[aw-1:0];
        w_b_acc_addr = w_in_idle ? cmd_addr : w_acc_addr;
        w_b_acc      = !w_in_idle;
        w_b_acc_last = !w_in_idle && (r_k == ACC_LAST);
    end

    always_comb begin
        w_beat = IDLE_INST;
        case (w_b_op)
            OP_XMEM_WR: begin
                w_beat[CEN_X_BIT]          = 1'b0;
                w_beat[WEN_X_BIT]          = 1'b0;
                w_beat[A_X_LSB +: aw]      = w_b_lin;
            end
            OP_IFIFO_FILL: begin
                w_beat[CEN_X_BIT]          = 1'b0;
                w_beat[IFIFO_WR_BIT]       = 1'b1;
                w_beat[A_X_LSB +: aw]      = w_b_lin;
            end
            OP_L0_FILL: begin
                w_beat[CEN_X_BIT]          = 1'b0;
                w_beat[L0_WR_BIT]          = 1'b1;
                w_beat[A_X_LSB +: aw]      = w_b_lin;
            end
            OP_LOAD: begin
                w_beat[IFIFO_RD_BIT]       = 1'b1;
                w_beat[LOAD_BIT]           = 1'b1;
            end
            OP_EXEC: begin
                w_beat[L0_RD_BIT]          = 1'b1;
                w_beat[EXEC_BIT]           = 1'b1;
            end
            OP_OFIFO_DRAIN: begin
                w_beat[OFIFO_RD_BIT]       = 1'b1;
                w_beat[CEN_P_BIT]          = 1'b0;
                w_beat[WEN_P_BIT]          = 1'b0;
                w_beat[A_P_LSB +: aw]      = w_b_lin;
            end
            OP_ACC: begin
                w_beat[ACC_BIT]            = w_b_acc;
                w_beat[CEN_P_BIT]          = w_b_acc_last;
                w_beat[A_P_LSB +: aw]      = w_b_acc_addr;
            end
            default: w_beat = IDLE_INST;
        endcase
    end

    // The generator stops advancing before the final read so the trailing
    // accumulate beat keeps the last read address.
    assign w_acc_start = w_accept && (cmd_op == OP_ACC);
    assign w_acc_step  = (r_state == ST_RUN) && (r_op == OP_ACC) && (r_k < ACC_STOP);

    acc_addr_gen #(
        .AW      (aw),
        .LEN_NIJ (len_nij),
        .KSIZE   (ksize),
        .IN_W    (in_w)
    ) u_acc_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_acc_start),
        .i_base  (cmd_addr),
        .i_step  (w_acc_step),
        .o_addr  (w_acc_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_base  <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_inst  <= IDLE_INST;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_base <= cmd_addr;
                        r_n    <= w_cmd_n;
                        if (w_cmd_empty) begin
                            r_state <= ST_GAP;
                            r_inst  <= IDLE_INST;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_inst  <= w_beat;
                            r_k     <= CW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (r_k == r_n) begin
                        r_state <= ST_GAP;
                        r_inst  <= IDLE_INST;
                        r_done  <= 1'b1;
                    end else begin
                        r_inst <= w_beat;
                        r_k    <= r_k + CW'(1);
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                    r_inst  <= IDLE_INST;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_inst  <= IDLE_INST;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign inst = r_inst;
    assign done = r_done;
    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_inst_gen.sv
// Directed bench for inst_gen: a table of commands with hand-computed first
// and last instruction words, a per-beat reference model, and corner sequences.
module tb_inst_gen;

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    typedef struct {
        logic [2:0]  op;
        logic [10:0] addr;
        logic [10:0] len;
        int          n;
        logic [33:0] first;
        logic [33:0] last;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [10:0] cmd_addr;
    logic [10:0] cmd_len;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    inst_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .inst      (inst),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%09h want 0x%09h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference beat built from the instruction-word layout; ACC address uses
    // an explicit multiply/divide form of the kernel walk.
    function automatic logic [33:0] model_beat(input logic [2:0] op, input logic [10:0] base, input int k);
        logic [33:0] w;
        logic [10:0] a;
        int kk;
        w = IDLE_W;
        a = base + 11'(k);
        case (op)
            3'd1: begin w[19] = 1'b0; w[18] = 1'b0; w[17:7] = a; end
            3'd2: begin w[19] = 1'b0; w[5] = 1'b1; w[17:7] = a; end
            3'd4: begin w[19] = 1'b0; w[2] = 1'b1; w[17:7] = a; end
            3'd3: begin w[4] = 1'b1; w[0] = 1'b1; end
            3'd5: begin w[3] = 1'b1; w[1] = 1'b1; end
            3'd6: begin w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = a; end
            3'd7: begin
                kk = (k < 9) ? k : 8;
                w[30:20] = 11'(int'(base) + kk * 36 + (kk / 3) * 6 + (kk % 3));
                w[32] = (k == 9);
                w[33] = (k != 0);
            end
            default: w = IDLE_W;
        endcase
        return w;
    endfunction

    // Called on the falling edge right after the accept edge.
    task automatic observe(input logic [2:0] op, input logic [10:0] addr, input int n,
                           output logic [33:0] first, output logic [33:0] last);
        first = IDLE_W;
        last  = IDLE_W;
        for (int k = 0; k < n; k++) begin
            check($sformatf("beat op%0d k%0d", op, k), inst, model_beat(op, addr, k));
            check("busy_in_run", 34'(busy), 34'd1);
            check("done_in_run", 34'(done), 34'd0);
            if (k == 0) first = inst;
            last = inst;
            @(negedge clk);
        end
        check("gap_inst", inst, IDLE_W);
        check("gap_done", 34'(done), 34'd1);
        check("gap_ready", 34'(cmd_ready), 34'd0);
        @(negedge clk);
        check("post_done", 34'(done), 34'd0);
        check("post_ready", 34'(cmd_ready), 34'd1);
        check("post_busy", 34'(busy), 34'd0);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [10:0] addr, input logic [10:0] len,
                           input int n, output logic [33:0] first, output logic [33:0] last);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        check("ready_at_issue", 34'(cmd_ready), 34'd1);
        @(negedge clk);
        // Scramble inputs after accept; the running command must ignore them.
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_addr  = ~addr;
        cmd_len   = ~len;
        observe(op, addr, n, first, last);
    endtask

    vec_t vecs[9];
    logic [33:0] got_first, got_last;
    int acc_seq[10];

    initial begin
        vecs[0] = '{3'd2, 11'h400, 11'd8,  9,  34'h1_8006_0020, 34'h1_8006_0420};
        vecs[1] = '{3'd6, 11'd72,  11'd36, 36, 34'h0_048C_0040, 34'h0_06BC_0040};
        vecs[2] = '{3'd5, 11'd0,   11'd52, 52, 34'h1_800C_000A, 34'h1_800C_000A};
        vecs[3] = '{3'd7, 11'd7,   11'd5,  10, 34'h0_807C_0000, 34'h3_935C_0000};
        vecs[4] = '{3'd1, 11'h7FE, 11'd4,  4,  34'h1_8003_FF00, 34'h1_8000_0080};
        vecs[5] = '{3'd3, 11'h123, 11'd0,  0,  IDLE_W,          IDLE_W};
        vecs[6] = '{3'd0, 11'h055, 11'd9,  0,  IDLE_W,          IDLE_W};
        vecs[7] = '{3'd4, 11'd5,   11'd1,  2,  34'h1_8004_0284, 34'h1_8004_0304};
        vecs[8] = '{3'd2, 11'd3,   11'd0,  0,  IDLE_W,          IDLE_W};
        acc_seq = '{7, 44, 81, 121, 158, 195, 235, 272, 309, 309};

        // Reset held with a command pending; it is taken right after release.
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_addr  = 11'd0;
        cmd_len   = 11'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_inst", inst, IDLE_W);
            check("rst_ready", 34'(cmd_ready), 34'd0);
            check("rst_done", 34'(done), 34'd0);
            check("rst_busy", 34'(busy), 34'd0);
        end
        reset = 1'b0;
        #1;
        check("ready_after_rst", 34'(cmd_ready), 34'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        observe(3'd5, 11'd0, 3, got_first, got_last);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].n, got_first, got_last);
            check($sformatf("vec%0d_first", i), got_first, vecs[i].first);
            check($sformatf("vec%0d_last", i), got_last, vecs[i].last);
        end

        // ACC walk against the hand-listed address sequence and acc/CEN bits.
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_addr  = 11'd7;
        cmd_len   = 11'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("acc_ap k%0d", k), 34'(inst[30:20]), 34'(acc_seq[k]));
            check($sformatf("acc_bit k%0d", k), 34'(inst[33]), 34'(k != 0));
            check($sformatf("acc_cenp k%0d", k), 34'(inst[32]), 34'(k == 9));
            @(negedge clk);
        end
        check("acc_gap_inst", inst, IDLE_W);
        check("acc_gap_done", 34'(done), 34'd1);
        @(negedge clk);

        // cmd_valid held high: accepted once per IDLE visit, back to back.
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_addr  = 11'd0;
        cmd_len   = 11'd2;
        @(negedge clk);
        observe(3'd3, 11'd0, 2, got_first, got_last);
        @(negedge clk);
        cmd_valid = 1'b0;
        observe(3'd3, 11'd0, 2, got_first, got_last);

        // Reset during beat 3 of an L0 fill drops the command without done.
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_addr  = 11'h010;
        cmd_len   = 11'd36;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("l0_pre_rst k%0d", k), inst, model_beat(3'd4, 11'h010, k));
            if (k < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_inst", inst, IDLE_W);
        check("midrst_done", 34'(done), 34'd0);
        check("midrst_busy", 34'(busy), 34'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_done2", 34'(done), 34'd0);
        check("midrst_ready", 34'(cmd_ready), 34'd1);
        run_cmd(3'd5, 11'd0, 11'd2, 2, got_first, got_last);
        check("exec_after_rst_first", got_first, 34'h1_800C_000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_gen.md
Name: inst_gen

Overview:
- Command-to-instruction expander for the accelerator core. It receives compact high-level commands from a host or sequencer over a valid/ready handshake.
- Each command is expanded cycle-by-cycle into the core's 34-bit instruction word, so the host no longer hand-toggles per-cycle control bits.
- Sits directly in front of the core's `inst` input. The `D_xmem` data path stays outside this block.

Parameters:
- `len_nij`, 36: psum rows per kij slice in pmem (input 6x6).
- `ksize`, 3: kernel width/height; the ACC op issues ksize*ksize reads.
- `in_w`, 6: input feature map width.
- `aw`, 11: SRAM address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  0 NOP, 1 XMEM_WR, 2 IFIFO_FILL, 3 LOAD, 4 L0_FILL, 5 EXEC, 6 OFIFO_DRAIN, 7 ACC.
- `cmd_addr`  in  aw  base address (ACC: base nij of the output pixel).
- `cmd_len`  in  aw  beat count (ignored for ACC/NOP).
- `inst`  out  34  core instruction word, registered.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at end of each command.

Behaviour:

Clocking and reset:
- One clock `clk`. Reset is synchronous and active-high.
- Reset values: state=IDLE; `inst` = idle word; `cmd_ready`=1; `busy`=0; `done`=0.
- Idle word: bits 32,31,19,18 (CEN_pmem, WEN_pmem, CEN_xmem, WEN_xmem) = 1; all other bits 0.

Instruction word layout:
- [33] acc
- [32] CEN_pmem
- [31] WEN_pmem
- [30:20] A_pmem
- [19] CEN_xmem
- [18] WEN_xmem
- [17:7] A_xmem
- [6] ofifo_rd
- [5] ififo_wr
- [4] ififo_rd
- [3] l0_rd
- [2] l0_wr
- [1] execute
- [0] load

Handshake:
- Accept on the rising edge where `cmd_valid` && `cmd_ready`.
- `cmd_ready` = (state==IDLE) && !reset.
- Beat 0 appears on `inst` at acceptance edge +1.

FSM:
- IDLE -> RUN on accept (NOP or len==0 -> GAP directly).
- RUN: beat counter k from 0 to N-1, then -> GAP.
- GAP: drive the idle word for exactly 1 cycle with `done`=1, then -> IDLE.
- Back-to-back commands therefore have a minimum spacing of N+2 cycles.

Per-op beats (unlisted bits take their idle-word value; addresses mod 2^aw):
- XMEM_WR: N=len. CEN_x=0, WEN_x=0, A_x=base+k.
- IFIFO_FILL: N=len+1. CEN_x=0, WEN_x=1, ififo_wr=1, A_x=base+k.
- L0_FILL: N=len+1. Same as IFIFO_FILL with l0_wr in place of ififo_wr.
- LOAD: N=len. ififo_rd=1, load=1.
- EXEC: N=len. l0_rd=1, execute=1.
- OFIFO_DRAIN: N=len. ofifo_rd=1, CEN_p=0, WEN_p=0, A_p=base+k.
- ACC: N=ksize*ksize+1.
  - Beats k<ksize²: CEN_p=0, WEN_p=1, A_p = base + kij*len_nij + kr*in_w + kc, where kij=k, kr=kij/ksize, kc=kij%ksize.
  - Last beat: CEN_p=1.
  - acc=1 on beats 1..N-1.
  - kr/kc and the running offset are computed with counters and adders only; no divider or multiplier.
  - The A_p value is held on the last beat.

Boundaries:
- len==0 on any non-ACC op: zero active beats; GAP plus `done` pulse only.
- Address increments wrap at 2^aw without error.
- `cmd_*` inputs are sampled only at accept; changes during RUN are ignored.
- Reset in any state: the next edge yields IDLE and the idle word, no `done` pulse, and the command is lost.
- `cmd_valid` held high continuously is accepted once per IDLE visit.

Decomposition:
- Shared package `inst_pkg`:
  - opcode localparams
  - instruction bit-index localparams (ACC_BIT, CEN_P_BIT, A_P_LSB, ...)
  - IDLE_INST constant
  - FSM state encoding
- Sub-module `acc_addr_gen`: counts kr/kc and produces the ACC read address; it has start/step inputs and an addr output.

Test Plan:
- Reset for 5 cycles with `cmd_valid`=1 -> `inst`=0x1_800C_0000 pattern (bits 32,31,19,18 set), `cmd_ready` rises on the first cycle after reset drops, `done`=0 throughout.
- IFIFO_FILL addr=0x400 len=8 -> 9 beats: A_x 0x400..0x408, ififo_wr=1, CEN_x=0, WEN_x=1. Then one idle cycle with `done`=1; `cmd_ready` returns on the following cycle.
- OFIFO_DRAIN addr=72 len=36 -> A_p 72..107, WEN_p=0, ofifo_rd=1 for exactly 36 cycles; EXEC len=52 -> l0_rd=execute=1 for exactly 52 cycles.
- ACC addr=7 -> A_p sequence 7, 44, 81, 121, 158, 195, 235, 272, 309. Then a 10th beat with CEN_p=1 and acc=1; acc=1 on beats 1..9 only.
- XMEM_WR addr=0x7FE len=4 -> A_x 0x7FE, 0x7FF, 0x000, 0x001 (wrap). Also LOAD len=0 -> `done` at accept+1 with no active beat.
- Assert reset on beat 3 of L0_FILL len=36 -> next `inst` is the idle word, no `done`; a new EXEC len=2 issued afterwards runs normally.
